// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stall requests, sequences exception flushes and holds the front end during refill.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned REFILL_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_for_load,
  input  logic        stallreq_for_cp0,
  input  logic        stallreq_for_bru,
  input  logic        stallreq_for_fifo,
  input  logic        stallreq_for_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_load_o,
  output logic [31:0] perf_bru_o,
  output logic [31:0] perf_fifo_o,
  output logic [31:0] perf_ex_o,
`endif
  output logic        busy_o
);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_e;

  localparam logic [3:0]  REFILL_LOAD = 4'(REFILL_CYCLES - 1);
  localparam logic [31:0] ERET_CODE   = 32'h0000_000E;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q;
  logic [31:0] new_pc_q, new_pc_d;

  function automatic logic [5:0] stall_merge(input logic ex, input logic ld_cp0, input logic bru_fifo);
    if (ex)            return 6'b001111;
    else if (ld_cp0)   return 6'b000111;
    else if (bru_fifo) return 6'b000011;
    else               return 6'b000000;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    stall    = 6'b000000;
    case (state_q)
      RUN: begin
        stall = stall_merge(stallreq_for_ex, stallreq_for_load | stallreq_for_cp0,
                            stallreq_for_bru | stallreq_for_fifo);
        if (excepttype_i != 32'h0) begin
          state_d  = FLUSH;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      FLUSH: begin
        cnt_d   = REFILL_LOAD;
        state_d = REFILL;
      end
      REFILL: begin
        // MEM only carries bubbles here, so exceptions cannot arrive; only EX busy can widen the stall.
        stall = stallreq_for_ex ? 6'b001111 : 6'b000011;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= (state_d == FLUSH);
      new_pc_q <= new_pc_d;
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;
  assign busy_o = (state_q != RUN);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_load_q, perf_bru_q, perf_fifo_q, perf_ex_q;
  logic        run_c, win_ex, win_load, win_low;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Only the winning priority tier is charged; cp0 has no counter of its own but still outranks bru/fifo.
  assign run_c    = (state_q == RUN);
  assign win_ex   = run_c & stallreq_for_ex;
  assign win_load = run_c & ~stallreq_for_ex & stallreq_for_load;
  assign win_low  = run_c & ~stallreq_for_ex & ~stallreq_for_load & ~stallreq_for_cp0;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_q <= 32'h0;
      perf_bru_q  <= 32'h0;
      perf_fifo_q <= 32'h0;
      perf_ex_q   <= 32'h0;
    end else begin
      perf_load_q <= sat_inc(perf_load_q, win_load);
      perf_bru_q  <= sat_inc(perf_bru_q, win_low & stallreq_for_bru);
      perf_fifo_q <= sat_inc(perf_fifo_q, win_low & stallreq_for_fifo);
      perf_ex_q   <= sat_inc(perf_ex_q, win_ex);
    end
  end

  assign perf_load_o = perf_load_q;
  assign perf_bru_o  = perf_bru_q;
  assign perf_fifo_o = perf_fifo_q;
  assign perf_ex_o   = perf_ex_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-timestamp reference model.
module tb_pipe_ctrl;
  localparam int R = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld, cp0, bru, fifo, ex;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush, busy;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] p_load, p_bru, p_fifo, p_ex;
  longint      m_load, m_bru, m_fifo, m_ex;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exc_at = -1000;
  logic [31:0] pc_exp = 32'h0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REFILL_CYCLES(R), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_for_load(ld), .stallreq_for_cp0(cp0), .stallreq_for_bru(bru),
    .stallreq_for_fifo(fifo), .stallreq_for_ex(ex),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
`ifdef PIPE_CTRL_PERF_EN
    .perf_load_o(p_load), .perf_bru_o(p_bru), .perf_fifo_o(p_fifo), .perf_ex_o(p_ex),
`endif
    .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  // req = {ex, fifo, bru, cp0, load}
  task automatic step(input logic r, input logic [4:0] req, input logic [31:0] e,
                      input logic [31:0] pc_in, input bit do_chk);
    logic        in_run, in_flush, in_refill;
    logic [5:0]  s_exp;
    @(negedge clk);
    cyc++;
    rst = r; {ex, fifo, bru, cp0, ld} = req; exc = e; epc = pc_in;
    #1;
    in_flush  = (cyc == exc_at + 1);
    in_refill = (cyc >= exc_at + 2) && (cyc <= exc_at + 1 + R);
    in_run    = !in_flush && !in_refill;
    if (in_flush)                s_exp = 6'd0;
    else if (req[4])             s_exp = 6'b001111;
    else if (in_refill)          s_exp = 6'b000011;
    else if (req[0] || req[1])   s_exp = 6'b000111;
    else if (req[2] || req[3])   s_exp = 6'b000011;
    else                         s_exp = 6'd0;
    if (do_chk) begin
      check("stall", 32'(stall), 32'(s_exp));
      check("flush", 32'(flush), 32'(in_flush));
      check("busy", 32'(busy), 32'(!in_run));
      check("new_pc", new_pc, pc_exp);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_load", p_load, 32'(m_load));
      check("perf_bru", p_bru, 32'(m_bru));
      check("perf_fifo", p_fifo, 32'(m_fifo));
      check("perf_ex", p_ex, 32'(m_ex));
`endif
    end
`ifdef PIPE_CTRL_PERF_EN
    if (r) begin
      m_load = 0; m_bru = 0; m_fifo = 0; m_ex = 0;
    end else if (in_run) begin
      if (req[4]) m_ex++;
      else if (req[0]) m_load++;
      else if (!req[1]) begin
        if (req[2]) m_bru++;
        if (req[3]) m_fifo++;
      end
    end
`endif
    if (r) begin
      exc_at = -1000;
      pc_exp = 32'h0;
    end else if (in_run && e != 32'h0) begin
      exc_at = cyc;
      pc_exp = (e == 32'hE) ? pc_in : VEC;
    end
  endtask

  initial begin
    logic [4:0]  rq;
    logic [31:0] ev;
    rst = 1'b1; {ex, fifo, bru, cp0, ld} = '0; exc = '0; epc = '0;
`ifdef PIPE_CTRL_PERF_EN
    m_load = 0; m_bru = 0; m_fifo = 0; m_ex = 0;
`endif
    step(1'b1, 5'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 5'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);

    // Load + fifo, then fifo alone
    step(1'b0, 5'b01001, 32'h0, 32'h0, 1'b1);
    check("ld_fifo_prio", 32'(stall), 32'h07);
    step(1'b0, 5'b01000, 32'h0, 32'h0, 1'b1);
    check("fifo_only", 32'(stall), 32'h03);

    // Plain exception, then bru held five cycles in RUN
    step(1'b0, 5'b0, 32'h1, 32'h0, 1'b1);
    step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
    check("exc_vector", new_pc, 32'hBFC0_0380);
    repeat (R + 1) step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
    repeat (5) step(1'b0, 5'b00100, 32'h0, 32'h0, 1'b1);

    // ERET with EPC redirect
    step(1'b0, 5'b0, 32'hE, 32'h8000_1234, 1'b1);
    step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
    check("eret_pc", new_pc, 32'h8000_1234);
    repeat (R) step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);

    // Exception with EX busy, second exception held through refill
    step(1'b0, 5'b10000, 32'h4, 32'h0, 1'b1);
    check("exc_with_ex", 32'(stall), 32'h0F);
    repeat (R + 1) step(1'b0, 5'b00001, 32'h8, 32'h0, 1'b1);
    step(1'b0, 5'b0, 32'h8, 32'h0, 1'b1);
    repeat (R + 2) step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);

    // Reset in the middle of refill
    step(1'b0, 5'b0, 32'h1, 32'h0, 1'b1);
    step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 5'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 5'b0, 32'h0, 32'h0, 1'b1);
    check("rst_midrefill_busy", 32'(busy), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rq = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rq[4] = 1'b1;
      else rq[4] = 1'b0;
      ev = 32'h0;
      if ($urandom_range(0, 7) == 0) ev = ($urandom_range(0, 1) == 0) ? 32'hE : (32'($urandom) | 32'h1);
      step(($urandom_range(0, 99) == 0), rq, ev, 32'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
